// File: rtl/seq_divide_if.sv
// Handshake and operand/result bundle for the seq_divide sequential divider.
// The divider connects through the slave modport; the requester uses master.
interface seq_divide_if #(
    parameter int N_WIDTH = 8,
    parameter int D_WIDTH = 8
);
    logic               start;
    logic [N_WIDTH-1:0] numerator;
    logic [D_WIDTH-1:0] denominator;
    logic               busy;
    logic               done;
    logic [N_WIDTH-1:0] quotient;
    logic [D_WIDTH-1:0] remain;
    logic               div_zero;

    modport master (
        output start, numerator, denominator,
        input  busy, done, quotient, remain, div_zero
    );

    modport slave (
        input  start, numerator, denominator,
        output busy, done, quotient, remain, div_zero
    );
endinterface

// File: rtl/seq_divide.sv
// Restoring shift-subtract divider that produces one quotient bit per clock, MSB first.
// Define DIV_ZERO_CHECK_EN to short-circuit zero divisors straight to DONE with div_zero set.
module seq_divide #(
    parameter int N_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    seq_divide_if.slave bus
);
    localparam int CW = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [N_WIDTH-1:0] num_sh;
    logic [N_WIDTH-1:0] quo_r;
    logic [N_WIDTH-1:0] q_next;
    logic [D_WIDTH:0]   part;
    logic [D_WIDTH:0]   shifted;
    logic [D_WIDTH:0]   part_next;
    logic [D_WIDTH-1:0] den;
    logic [D_WIDTH-1:0] rem_r;
    logic               busy_r;
    logic               done_r;
    logic               q_bit;
    logic               accept;
`ifdef DIV_ZERO_CHECK_EN
    logic               dz_r;
`endif

    // num_sh shifts dividend bits out of the top while quotient bits fill in at the bottom.
    always_comb begin
        shifted   = {part[D_WIDTH-1:0], num_sh[N_WIDTH-1]};
        part_next = shifted;
        q_bit     = 1'b0;
        if (shifted >= {1'b0, den}) begin
            part_next = shifted - {1'b0, den};
            q_bit     = 1'b1;
        end
        q_next = (num_sh << 1) | N_WIDTH'(q_bit);
        accept = bus.start && (state != CALC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            num_sh <= '0;
            part   <= '0;
            den    <= '0;
            quo_r  <= '0;
            rem_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
            dz_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                    if (accept) begin
                        num_sh <= bus.numerator;
                        den    <= bus.denominator;
                        part   <= '0;
                        cnt    <= '0;
`ifdef DIV_ZERO_CHECK_EN
                        if (bus.denominator == '0) begin
                            state  <= DONE;
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            quo_r  <= '1;
                            rem_r  <= D_WIDTH'(bus.numerator);
                            dz_r   <= 1'b1;
                        end else begin
                            state  <= CALC;
                            busy_r <= 1'b1;
                        end
`else
                        state  <= CALC;
                        busy_r <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    part   <= part_next;
                    num_sh <= q_next;
                    cnt    <= cnt + 1'b1;
                    // Results are published on the final step edge so DONE sees them at once.
                    if (cnt == LAST_STEP) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        quo_r  <= q_next;
                        rem_r  <= part_next[D_WIDTH-1:0];
`ifdef DIV_ZERO_CHECK_EN
                        dz_r   <= 1'b0;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.quotient = quo_r;
    assign bus.remain   = rem_r;
`ifdef DIV_ZERO_CHECK_EN
    assign bus.div_zero = dz_r;
`else
    assign bus.div_zero = 1'b0;
`endif
endmodule

// File: doc/seq_divide.md
SEQ_DIVIDE -- requirements
Module: seq_divide

Interface
REQ-001 SHALL have parameter N_WIDTH, default 8, giving the numerator and quotient width in bits.
REQ-002 SHALL have parameter D_WIDTH, default 8, giving the denominator and remainder width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to begin a division.
REQ-006 SHALL have port numerator, input, N_WIDTH, unsigned dividend; sampled only when start is accepted.
REQ-007 SHALL have port denominator, input, D_WIDTH, unsigned divisor; sampled only when start is accepted.
REQ-008 SHALL have port busy, output, 1, high while an iteration is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the result becomes valid.
REQ-010 SHALL have port quotient, output, N_WIDTH, registered result.
REQ-011 SHALL have port remain, output, D_WIDTH, registered remainder.
REQ-012 SHALL have port div_zero, output, 1, registered flag marking a zero-divisor result.

Function
REQ-013 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-014 SHALL accept start only when busy=0 (IDLE or DONE), latching both operands and clearing the iteration counter, then entering CALC.
REQ-015 SHALL ignore start while in CALC, with no effect on the operation in progress or its operands.
REQ-016 SHALL perform one restoring shift-subtract step per cycle in CALC, MSB first, using a partial remainder of D_WIDTH+1 bits.
REQ-017 SHALL leave CALC after exactly N_WIDTH steps and update quotient/remain on that same edge; done is therefore high in the cycle N_WIDTH+1 edges after the start edge.
REQ-018 SHALL hold busy=1 for exactly N_WIDTH cycles per operation.
REQ-019 SHALL keep done=1 for exactly one cycle (DONE state), then return to IDLE unless start is accepted in DONE, in which case it enters CALC directly.
REQ-020 SHALL hold quotient, remain and div_zero stable from DONE until the next completing operation; they SHALL NOT change during CALC.
REQ-021 SHALL produce quotient = floor(numerator/denominator) and remain = numerator mod denominator for denominator != 0; remain < denominator always.
REQ-022 SHALL handle the boundaries numerator=0, denominator=1 and numerator<denominator exactly, including quotient all-ones for numerator=2^N_WIDTH-1 with denominator=1.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, go to IDLE and set busy=0, done=0, quotient=0, remain=0, div_zero=0, with counter and working registers cleared.
REQ-024 SHALL abort an operation when rst is asserted mid-CALC; no done pulse is produced for the aborted operation.
REQ-025 SHALL give rst priority over start on the same edge.

Configuration
REQ-026 SHALL support macro DIV_ZERO_CHECK_EN.
REQ-027 SHALL, with DIV_ZERO_CHECK_EN defined, on accepting start with denominator=0, skip CALC and go straight to DONE on the start edge, with busy never high; the outputs in DONE are quotient=all ones, remain=numerator[D_WIDTH-1:0] and div_zero=1.
REQ-028 SHALL, with DIV_ZERO_CHECK_EN defined, clear div_zero for any completion with a nonzero denominator.
REQ-029 SHALL, without DIV_ZERO_CHECK_EN, tie div_zero to 0 and run the full N_WIDTH-step iteration for denominator=0, yielding quotient=all ones and remain=numerator[D_WIDTH-1:0].

Verification
REQ-030 SHALL cover a basic case with defaults: nu=3, de=8 -> after 8 busy cycles, done pulses once with quotient=0, remain=3; then nu=11, de=8 -> quotient=1, remain=3.
REQ-031 SHALL cover arithmetic boundaries: 255/1 -> q=255, r=0; 200/7 -> q=28, r=4; 0/5 -> q=0, r=0; 7/255 -> q=0, r=7.
REQ-032 SHALL cover start while busy: pulse start with 100/3, then pulse start with 9/9 at CALC cycle 3 -> single done with q=33, r=1, and the second request is ignored.
REQ-033 SHALL cover back-to-back operation: start held high continuously with 50/6 -> done every 9 cycles (8 CALC + 1 DONE), each with q=8, r=2.
REQ-034 SHALL cover reset mid-operation: start 200/7, assert rst at CALC cycle 4 -> all outputs 0 next cycle, no done; a new 20/3 -> q=6, r=2.
REQ-035 SHALL cover divide by zero: 13/0 with DIV_ZERO_CHECK_EN -> done on the cycle after start, busy never high, q=255, r=13, div_zero=1; without the macro -> done after 8 busy cycles, q=255, r=13, div_zero=0.
